queueing_domain_multiport: RTL and testbench
============================================

Name: queueing_domain_multiport

Overview:
- Parametrised successor of the single-input queueing/scheduling domain.
- Accepts packets from NUMBER_OF_INPUTS packetizer ports, each tagged with a destination queue id, and stores them in NUMBER_OF_QUEUES FIFOs.
- Selects one queue head per cycle, using round-robin or fixed-priority arbitration, into a registered valid/ready output stage toward the serializer.
- Adds per-input backpressure, input-collision arbitration, and per-queue occupancy/threshold kill flags of parametric width.

Parameters:
- NUMBER_OF_INPUTS, 2, packetizer input ports (>=1).
- NUMBER_OF_QUEUES, 4, FIFO count (>=2, power of two).
- QUEUE_LENGTH, 16, entries per FIFO (power of two, >=2).
- DATA_SIZE, 678, packet width in bits.
- PRIORITY_SIZE, 4, width of each per-queue priority.
- QW, $clog2(NUMBER_OF_QUEUES), id width (derived).
- OW, $clog2(QUEUE_LENGTH)+1, occupancy width (derived).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_packet  in  NUMBER_OF_INPUTS x DATA_SIZE  packets per input.
- in_valid  in  NUMBER_OF_INPUTS  packet present.
- in_id  in  NUMBER_OF_INPUTS x QW  destination queue.
- in_ready  out  NUMBER_OF_INPUTS  packet accepted this cycle (combinational).
- scheduling_mode  in  1  0 = round-robin, 1 = fixed priority.
- priorities  in  NUMBER_OF_QUEUES x PRIORITY_SIZE  FP priority; larger value wins.
- thresholds  in  NUMBER_OF_QUEUES x OW  kill threshold; 0 disables.
- out_valid  out  1  output packet valid.
- out_packet  out  DATA_SIZE  output packet.
- out_id  out  QW  source queue of out_packet.
- out_ready  in  1  serializer accepts.
- occupancy  out  NUMBER_OF_QUEUES x OW  registered fill level per queue.
- empty  out  NUMBER_OF_QUEUES  occupancy==0.
- full  out  NUMBER_OF_QUEUES  occupancy==QUEUE_LENGTH.
- kill_the_core  out  NUMBER_OF_QUEUES  registered threshold flag.

Behaviour:
- Reset (synchronous, active-high):
  - Clears all FIFO pointers and occupancy.
  - Forces out_valid=0, out_packet=0, out_id=0, kill_the_core=0, round-robin pointer=0.
  - empty=all 1, full=all 0.
  - Reset mid-operation flushes all stored packets. in_ready=0 while reset is high.
- Input acceptance (combinational):
  - Input i gets in_ready=1 iff in_valid[i], full[in_id[i]]==0, and no lower-index valid input targets the same queue.
  - Collision rule: lowest input index wins; losers see in_ready=0 and must hold their packet.
  - At most one write per queue per cycle.
  - Full check uses registered occupancy. A same-cycle dequeue does not free space for a same-cycle enqueue.
- Enqueue: on clock edge with in_valid&in_ready, the packet is written at the tail; occupancy +1.
- Eligibility: queue q is eligible iff occupancy[q]!=0. A packet written at edge t is eligible from cycle t+1.
- Load condition: the output stage loads when (out_valid==0 || out_ready==1) and at least one queue is eligible.
- On load:
  - out_packet <= head of winner, out_id <= winner, out_valid <= 1.
  - Winner occupancy -1, in the same edge.
  - Minimum enqueue-to-out_valid latency: 2 cycles.
- Hold: if out_valid && !out_ready, out_packet and out_id stay stable and no dequeue occurs.
- Drain: if out_ready && no eligible queue, out_valid <= 0.
- Simultaneous enqueue and dequeue on the same queue: occupancy unchanged, both take effect.
- Round-robin mode:
  - Search starts at rr_ptr and wraps modulo NUMBER_OF_QUEUES.
  - On grant to q, rr_ptr <= (q+1) mod NUMBER_OF_QUEUES.
  - rr_ptr is unchanged when there is no grant.
- Fixed-priority mode:
  - The eligible queue with the highest priorities[] wins; ties go to the lowest index.
  - rr_ptr is not updated.
- scheduling_mode and priorities are evaluated only in cycles where a load occurs. Switching mode never corrupts the output stage.
- Status flags:
  - kill_the_core[q] <= (thresholds[q]!=0) && (next occupancy[q] >= thresholds[q]); registered, same edge as occupancy.
  - empty and full derive from registered occupancy.
- Pointers are QUEUE_LENGTH-modulo and wrap naturally. Occupancy never exceeds QUEUE_LENGTH nor underflows; assertions cover both.

Test Plan:
- Reset, then input 0 sends packet A to queue 2 at cycle 1 with out_ready=1 -> in_ready[0]=1, occupancy[2]=1 after the edge, out_valid=1 with out_packet=A and out_id=2 at cycle 3, occupancy[2]=0.
- Inputs 0 and 1 both target queue 1 in the same cycle -> in_ready=2'b01. Input 1 holds its packet and is accepted the next cycle. Output order is input-0 packet then input-1 packet.
- Fill queue 0 with 16 packets while out_ready=0 -> full[0]=1, 17th packet sees in_ready=0. With thresholds[0]=12, kill_the_core[0] rises on the edge where occupancy reaches 12. Raising out_ready drains 1 packet per cycle, and kill falls when occupancy reaches 11.
- RR mode, queues 0..3 each hold 2 packets, out_ready=1 -> out_id sequence 0,1,2,3,0,1,2,3, then out_valid=0.
- FP mode, priorities {q3=1, q2=9, q1=9, q0=2}, all queues non-empty -> queue 1 drains first (tie goes to lower index), then queue 2, then 0, then 3. Switching to RR mid-stream takes effect on the next load only.
- out_ready held low for 5 cycles with out_valid=1 -> out_packet and out_id stable, no occupancy change. Reset asserted with queues non-empty -> next cycle all empty=1, out_valid=0, kill_the_core=0.

Source files
------------

// File: rtl/queueing_domain_multiport.sv
// queueing_domain_multiport: multi-input packet queues with RR/FP scheduling into a registered output stage
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   in_packet/in_valid/in_id/in_ready   per-input packet, valid, destination queue, combinational accept
//   scheduling_mode   0 = round-robin, 1 = fixed priority (larger priorities[] wins)
//   thresholds        per-queue kill threshold, 0 disables
//   out_valid/out_packet/out_id/out_ready   registered output stage toward the serializer
//   occupancy/empty/full/kill_the_core      per-queue registered status
module queueing_domain_multiport #(
    parameter int NUMBER_OF_INPUTS = 2,
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int QUEUE_LENGTH     = 16,
    parameter int DATA_SIZE        = 678,
    parameter int PRIORITY_SIZE    = 4,
    parameter int QW               = $clog2(NUMBER_OF_QUEUES),
    parameter int OW               = $clog2(QUEUE_LENGTH) + 1
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [NUMBER_OF_INPUTS*DATA_SIZE-1:0]  in_packet,
    input  logic [NUMBER_OF_INPUTS-1:0]            in_valid,
    input  logic [NUMBER_OF_INPUTS*QW-1:0]         in_id,
    output logic [NUMBER_OF_INPUTS-1:0]            in_ready,
    input  logic                                   scheduling_mode,
    input  logic [NUMBER_OF_QUEUES*PRIORITY_SIZE-1:0] priorities,
    input  logic [NUMBER_OF_QUEUES*OW-1:0]         thresholds,
    output logic                                   out_valid,
    output logic [DATA_SIZE-1:0]                   out_packet,
    output logic [QW-1:0]                          out_id,
    input  logic                                   out_ready,
    output logic [NUMBER_OF_QUEUES*OW-1:0]         occupancy,
    output logic [NUMBER_OF_QUEUES-1:0]            empty,
    output logic [NUMBER_OF_QUEUES-1:0]            full,
    output logic [NUMBER_OF_QUEUES-1:0]            kill_the_core
);
    localparam int AW = $clog2(QUEUE_LENGTH);

    logic [DATA_SIZE-1:0]        mem_q [NUMBER_OF_QUEUES][QUEUE_LENGTH];
    logic [AW-1:0]               wr_ptr_q [NUMBER_OF_QUEUES];
    logic [AW-1:0]               rd_ptr_q [NUMBER_OF_QUEUES];
    logic [OW-1:0]               occ_q [NUMBER_OF_QUEUES];
    logic [OW-1:0]               occ_d [NUMBER_OF_QUEUES];
    logic [DATA_SIZE-1:0]        wr_data [NUMBER_OF_QUEUES];
    logic [NUMBER_OF_QUEUES-1:0] wr_en, rd_en, claimed, kill_q;
    logic [QW-1:0]               rr_ptr_q, grant, idx, out_id_q;
    logic [PRIORITY_SIZE-1:0]    best;
    logic [DATA_SIZE-1:0]        out_packet_q;
    logic                        out_valid_q, found, load;

    // claimed marks queues already targeted by a lower-index valid input, so a
    // loser stays blocked even when the winner itself is stalled by a full queue
    always_comb begin
        in_ready = '0;
        wr_en = '0;
        claimed = '0;
        for (int q = 0; q < NUMBER_OF_QUEUES; q++) wr_data[q] = '0;
        for (int i = 0; i < NUMBER_OF_INPUTS; i++) begin
            if (!reset && in_valid[i] && !full[in_id[i*QW +: QW]] && !claimed[in_id[i*QW +: QW]]) begin
                in_ready[i] = 1'b1;
                wr_en[in_id[i*QW +: QW]] = 1'b1;
                wr_data[in_id[i*QW +: QW]] = in_packet[i*DATA_SIZE +: DATA_SIZE];
            end
            if (in_valid[i]) claimed[in_id[i*QW +: QW]] = 1'b1;
        end
    end

    // RR scans offsets high to low so the smallest offset from rr_ptr is kept;
    // FP uses strict > so ties stay with the lowest index
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx = '0;
        best = '0;
        if (scheduling_mode) begin
            for (int q = 0; q < NUMBER_OF_QUEUES; q++)
                if (occ_q[q] != '0 && (!found || priorities[q*PRIORITY_SIZE +: PRIORITY_SIZE] > best)) begin
                    found = 1'b1;
                    grant = QW'(q);
                    best = priorities[q*PRIORITY_SIZE +: PRIORITY_SIZE];
                end
        end else begin
            for (int k = NUMBER_OF_QUEUES - 1; k >= 0; k--) begin
                idx = rr_ptr_q + QW'(k);
                if (occ_q[idx] != '0) begin
                    found = 1'b1;
                    grant = idx;
                end
            end
        end
    end

    assign load = (!out_valid_q || out_ready) && found;

    always_comb begin
        rd_en = '0;
        if (load) rd_en[grant] = 1'b1;
        for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
            occ_d[q] = occ_q[q] + OW'(wr_en[q]) - OW'(rd_en[q]);
            occupancy[q*OW +: OW] = occ_q[q];
            empty[q] = occ_q[q] == '0;
            full[q] = occ_q[q] == OW'(QUEUE_LENGTH);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
                wr_ptr_q[q] <= '0;
                rd_ptr_q[q] <= '0;
                occ_q[q] <= '0;
            end
            kill_q <= '0;
            rr_ptr_q <= '0;
            out_valid_q <= 1'b0;
            out_packet_q <= '0;
            out_id_q <= '0;
        end else begin
            for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
                if (wr_en[q]) wr_ptr_q[q] <= wr_ptr_q[q] + AW'(1);
                if (rd_en[q]) rd_ptr_q[q] <= rd_ptr_q[q] + AW'(1);
                occ_q[q] <= occ_d[q];
                kill_q[q] <= (thresholds[q*OW +: OW] != '0) && (occ_d[q] >= thresholds[q*OW +: OW]);
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_packet_q <= mem_q[grant][rd_ptr_q[grant]];
                out_id_q <= grant;
                if (!scheduling_mode) rr_ptr_q <= grant + QW'(1);
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int q = 0; q < NUMBER_OF_QUEUES; q++)
            if (wr_en[q]) mem_q[q][wr_ptr_q[q]] <= wr_data[q];
    end

    assign out_valid = out_valid_q;
    assign out_packet = out_packet_q;
    assign out_id = out_id_q;
    assign kill_the_core = kill_q;

    for (genvar q = 0; q < NUMBER_OF_QUEUES; q++) begin : g_chk
        assert property (@(posedge clock) disable iff (reset) occ_q[q] <= OW'(QUEUE_LENGTH));
        assert property (@(posedge clock) disable iff (reset) !(rd_en[q] && occ_q[q] == '0));
    end
endmodule

// File: tb/tb_queueing_domain_multiport.sv
// tb_queueing_domain_multiport: randomized bench against a packet-queue reference model
module tb_queueing_domain_multiport;
    localparam int NI = 2, NQ = 4, QL = 16, DS = 678, PS = 4, QW = 2, OW = 5;
    localparam int PW = NQ * PS;
    localparam int TW = NQ * OW;
    typedef logic [DS-1:0] pkt_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [NI*DS-1:0] in_packet;
    logic [NI-1:0]    in_valid, in_ready;
    logic [NI*QW-1:0] in_id;
    logic             scheduling_mode = 1'b0;
    logic [PW-1:0]    priorities = '0;
    logic [TW-1:0]    thresholds = '0;
    logic             out_valid, out_ready = 1'b0;
    logic [DS-1:0]    out_packet;
    logic [QW-1:0]    out_id;
    logic [TW-1:0]    occupancy;
    logic [NQ-1:0]    empty, full, kill_the_core;

    pkt_t          pk[NI];
    logic [QW-1:0] idv[NI];
    logic [NI-1:0] vld = '0;
    logic [NI-1:0] hold = '0;

    for (genvar g = 0; g < NI; g++) begin : g_in
        assign in_packet[g*DS +: DS] = pk[g];
        assign in_id[g*QW +: QW] = idv[g];
    end
    assign in_valid = vld;

    queueing_domain_multiport dut (
        .clock(clock), .reset(reset),
        .in_packet(in_packet), .in_valid(in_valid), .in_id(in_id), .in_ready(in_ready),
        .scheduling_mode(scheduling_mode), .priorities(priorities), .thresholds(thresholds),
        .out_valid(out_valid), .out_packet(out_packet), .out_id(out_id), .out_ready(out_ready),
        .occupancy(occupancy), .empty(empty), .full(full), .kill_the_core(kill_the_core)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(string tag, pkt_t got, pkt_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    pkt_t          mq[NQ][$];
    logic          m_ov = 1'b0;
    pkt_t          m_pkt = '0;
    int            m_id = 0;
    int            m_rr = 0;
    logic [NQ-1:0] m_kill = '0;
    logic [NI-1:0] exp_rdy;

    function automatic pkt_t rand_pkt();
        pkt_t p = '0;
        for (int k = 0; k < 22; k++) p = (p << 32) | pkt_t'($urandom());
        return p;
    endfunction

    function automatic logic [NI-1:0] model_ready();
        logic [NI-1:0] r;
        for (int i = 0; i < NI; i++) begin
            r[i] = !reset && vld[i] && mq[idv[i]].size() < QL;
            for (int j = 0; j < i; j++)
                if (vld[j] && idv[j] == idv[i]) r[i] = 1'b0;
        end
        return r;
    endfunction

    task automatic model_edge();
        int w, best;
        if (reset) begin
            for (int q = 0; q < NQ; q++) mq[q].delete();
            m_ov = 1'b0; m_pkt = '0; m_id = 0; m_rr = 0; m_kill = '0;
            return;
        end
        w = -1;
        best = -1;
        if (scheduling_mode) begin
            for (int q = 0; q < NQ; q++)
                if (mq[q].size() > 0 && int'(priorities[q*PS +: PS]) > best) begin
                    best = int'(priorities[q*PS +: PS]);
                    w = q;
                end
        end else begin
            for (int k = 0; k < NQ; k++)
                if (w < 0 && mq[(m_rr + k) % NQ].size() > 0) w = (m_rr + k) % NQ;
        end
        if ((!m_ov || out_ready) && w >= 0) begin
            m_pkt = mq[w].pop_front();
            m_ov = 1'b1;
            m_id = w;
            if (!scheduling_mode) m_rr = (w + 1) % NQ;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        for (int i = 0; i < NI; i++)
            if (exp_rdy[i]) mq[idv[i]].push_back(pk[i]);
        for (int q = 0; q < NQ; q++)
            m_kill[q] = thresholds[q*OW +: OW] != '0 && mq[q].size() >= int'(thresholds[q*OW +: OW]);
    endtask

    task automatic check_outputs();
        logic [NQ-1:0] e_empty, e_full;
        check("out_valid", pkt_t'(out_valid), pkt_t'(m_ov));
        check("out_packet", out_packet, m_pkt);
        check("out_id", pkt_t'(out_id), pkt_t'(m_id));
        for (int q = 0; q < NQ; q++) begin
            check($sformatf("occupancy%0d", q), pkt_t'(occupancy[q*OW +: OW]), pkt_t'(mq[q].size()));
            e_empty[q] = mq[q].size() == 0;
            e_full[q] = mq[q].size() == QL;
        end
        check("empty", pkt_t'(empty), pkt_t'(e_empty));
        check("full", pkt_t'(full), pkt_t'(e_full));
        check("kill_the_core", pkt_t'(kill_the_core), pkt_t'(m_kill));
    endtask

    task automatic tick();
        #1;
        exp_rdy = model_ready();
        check("in_ready", pkt_t'(in_ready), pkt_t'(exp_rdy));
        hold = vld & ~exp_rdy;
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(int pv, int pr, int idmax, bit mode_rnd);
        for (int i = 0; i < NI; i++)
            if (!hold[i]) begin
                vld[i] = $urandom_range(99) < pv;
                idv[i] = QW'($urandom_range(idmax));
                pk[i] = rand_pkt();
            end
        out_ready = $urandom_range(99) < pr;
        priorities = PW'($urandom());
        if (mode_rnd && $urandom_range(15) == 0) scheduling_mode = ~scheduling_mode;
    endtask

    task automatic run(int n, int pv, int pr, int idmax, bit mode_rnd);
        for (int c = 0; c < n; c++) begin
            drive(pv, pr, idmax, mode_rnd);
            tick();
        end
    endtask

    task automatic rand_thresholds();
        for (int q = 0; q < NQ; q++) thresholds[q*OW +: OW] = OW'($urandom_range(QL));
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            pk[i] = '0;
            idv[i] = '0;
        end
        run(3, 50, 50, NQ - 1, 1'b0);
        reset = 1'b0;
        hold = '0;
        vld = 2'b01; idv[0] = 2'd2; pk[0] = rand_pkt(); out_ready = 1'b1;
        tick();
        vld = '0;
        for (int c = 0; c < 4; c++) tick();
        hold = '0;
        vld = 2'b11; idv[0] = 2'd1; idv[1] = 2'd1; pk[0] = rand_pkt(); pk[1] = rand_pkt();
        tick();
        for (int c = 0; c < 5; c++) begin
            vld = vld & hold;
            tick();
        end
        thresholds = '0;
        thresholds[0 +: OW] = OW'(12);
        scheduling_mode = 1'b0;
        run(60, 90, 0, 0, 1'b0);
        run(30, 0, 100, NQ - 1, 1'b0);
        rand_thresholds();
        run(300, 50, 70, NQ - 1, 1'b1);
        rand_thresholds();
        run(80, 80, 20, NQ - 1, 1'b1);
        run(100, 70, 60, 1, 1'b1);
        scheduling_mode = 1'b1;
        run(60, 60, 50, NQ - 1, 1'b0);
        run(20, 90, 0, NQ - 1, 1'b0);
        reset = 1'b1;
        run(2, 50, 50, NQ - 1, 1'b0);
        reset = 1'b0;
        rand_thresholds();
        run(200, 50, 60, NQ - 1, 1'b1);
        run(60, 0, 100, NQ - 1, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
